// File: rtl/full_adder_4b.sv
//-----------------------------------------------------------------------------
// full_adder_4b
//
// Purpose:
//   Parameterised ripple-carry adder. It has a carry-in, a carry-out and a
//   two's-complement overflow flag. The sum and flags are combinational, so
//   downstream ALU logic can use them in the same cycle. A registered copy of
//   the result is also provided for pipelined consumers. That copy is
//   qualified by valid and adds zero and negative flags.
//
// Parameters:
//   WIDTH         operand/result width in bits (>= 2), default 4
//
// Ports:
//   clk           clock, registers update on the rising edge
//   rst           asynchronous, active-high reset (registered stage only)
//   A, B          operands (unsigned or two's complement)
//   Cin           carry-in
//   F             combinational sum, A + B + Cin mod 2^WIDTH
//   Cout          combinational carry-out of the MSB
//   overflow      combinational two's-complement overflow
//   in_valid      capture strobe for the registered stage
//   F_q           registered F
//   Cout_q        registered Cout
//   ovf_q         registered overflow
//   zero_q        registered (F == 0)
//   neg_q         registered F[WIDTH-1]
//   out_valid     registered in_valid
//
// Optional feature (macro STICKY_OVF_EN):
//   sticky_clr    in:  clears ovf_sticky at a clock edge (clear wins over set)
//   ovf_sticky    out: sets when an edge captures overflow=1 with in_valid=1
//   When the macro is undefined, these ports and the sticky logic are absent.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module full_adder_4b_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (p & ci);
    end
endmodule

module full_adder_4b #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Cout,
    output logic             overflow,
    output logic [WIDTH-1:0] F,
    input  logic             in_valid,
    output logic [WIDTH-1:0] F_q,
    output logic             Cout_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             neg_q,
    output logic             out_valid
`ifdef STICKY_OVF_EN
    ,
    input  logic             sticky_clr,
    output logic             ovf_sticky
`endif
);
    localparam int unsigned MSB = WIDTH - 1;

    //-------------------------------------------------------------------------
    // Combinational ripple-carry chain
    //-------------------------------------------------------------------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_4b_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    logic ovf_c;
    logic zero_c;

    always_comb begin
        // Cin contributes to the sum only. Overflow is judged from the operand
        // signs against the sign of the result.
        ovf_c  = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
        zero_c = (sum == '0);
    end

    assign F        = sum;
    assign Cout     = carry[WIDTH];
    assign overflow = ovf_c;

    //-------------------------------------------------------------------------
    // Registered result stage
    //-------------------------------------------------------------------------
    logic [WIDTH-1:0] f_d,    f_q;
    logic             cout_d, cout_q;
    logic             ovf_d,  ovf_q_r;
    logic             zero_d, zero_q_r;
    logic             neg_d,  neg_q_r;
    logic             vld_q;

    always_comb begin
        f_d    = f_q;
        cout_d = cout_q;
        ovf_d  = ovf_q_r;
        zero_d = zero_q_r;
        neg_d  = neg_q_r;
        if (in_valid) begin
            f_d    = sum;
            cout_d = carry[WIDTH];
            ovf_d  = ovf_c;
            zero_d = zero_c;
            neg_d  = sum[MSB];
        end
    end

    // The zero flag resets to 1 so that it is consistent with F_q == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q_r  <= 1'b0;
            zero_q_r <= 1'b1;
            neg_q_r  <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            f_q      <= f_d;
            cout_q   <= cout_d;
            ovf_q_r  <= ovf_d;
            zero_q_r <= zero_d;
            neg_q_r  <= neg_d;
            vld_q    <= in_valid;
        end
    end

    assign F_q       = f_q;
    assign Cout_q    = cout_q;
    assign ovf_q     = ovf_q_r;
    assign zero_q    = zero_q_r;
    assign neg_q     = neg_q_r;
    assign out_valid = vld_q;

`ifdef STICKY_OVF_EN
    //-------------------------------------------------------------------------
    // Sticky overflow: a clear on the same edge overrides a new set
    //-------------------------------------------------------------------------
    logic sticky_d, sticky_q;

    always_comb begin
        sticky_d = sticky_q;
        if (in_valid && ovf_c) begin
            sticky_d = 1'b1;
        end
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_full_adder_4b.sv
`timescale 1ns/1ps

module tb_full_adder_4b;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         Cout, overflow;
    logic [W-1:0] F;
    logic         in_valid;
    logic [W-1:0] F_q;
    logic         Cout_q, ovf_q, zero_q, neg_q, out_valid;
`ifdef STICKY_OVF_EN
    logic         sticky_clr;
    logic         ovf_sticky;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    full_adder_4b #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Cout      (Cout),
        .overflow  (overflow),
        .F         (F),
        .in_valid  (in_valid),
        .F_q       (F_q),
        .Cout_q    (Cout_q),
        .ovf_q     (ovf_q),
        .zero_q    (zero_q),
        .neg_q     (neg_q),
        .out_valid (out_valid)
`ifdef STICKY_OVF_EN
        ,
        .sticky_clr(sticky_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag, input logic [W-1:0] ef, input logic ec, input logic eo);
        chk({tag, ".F"}, 32'(F), 32'(ef));
        chk({tag, ".Cout"}, 32'(Cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    endtask

    task automatic chk_reg(input string tag, input logic [W-1:0] ef, input logic ec, input logic eo,
                           input logic ez, input logic en, input logic ev);
        chk({tag, ".F_q"}, 32'(F_q), 32'(ef));
        chk({tag, ".Cout_q"}, 32'(Cout_q), 32'(ec));
        chk({tag, ".ovf_q"}, 32'(ovf_q), 32'(eo));
        chk({tag, ".zero_q"}, 32'(zero_q), 32'(ez));
        chk({tag, ".neg_q"}, 32'(neg_q), 32'(en));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0;
`ifdef STICKY_OVF_EN
        sticky_clr = 1'b0;
`endif
        // Reset state before any clock edge
        #2;
        chk_reg("reset0", 4'h0, 0, 0, 1, 0, 0);
`ifdef STICKY_OVF_EN
        chk("reset0.sticky", 32'(ovf_sticky), 32'd0);
`endif

        @(negedge clk);
        rst = 1'b0;

        // Basic sums
        A = 4'b0001; B = 4'b0010; Cin = 1'b0; #1;
        chk_comb("1+2", 4'b0011, 0, 0);
        Cin = 1'b1; #1;
        chk_comb("1+2+1", 4'b0100, 0, 0);

        // Capture a nonzero result
        Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk_reg("cap3", 4'h3, 0, 0, 0, 0, 1);

        // All-ones + 1 wraps to zero
        @(negedge clk);
        A = 4'b1111; B = 4'b0001; Cin = 1'b0; #1;
        chk_comb("F+1", 4'b0000, 1, 0);
        @(posedge clk); #1;
        chk_reg("capF+1", 4'h0, 1, 0, 1, 0, 1);

        // Max positive + 1 gives min negative with overflow
        @(negedge clk);
        A = 4'b0111; B = 4'b0001; Cin = 1'b0; #1;
        chk_comb("7+1", 4'b1000, 0, 1);
        Cin = 1'b1; #1;
        chk_comb("7+1+1", 4'b1001, 0, 1);
        @(posedge clk); #1;
        chk_reg("cap7+1+1", 4'h9, 0, 1, 0, 1, 1);
`ifdef STICKY_OVF_EN
        chk("sticky.set", 32'(ovf_sticky), 32'd1);
`endif

        // Hold for three cycles with changing operands
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = 4'(i + 2); B = 4'(3 * i + 5); Cin = 1'(i);
            @(posedge clk); #1;
            chk_reg($sformatf("hold%0d", i), 4'h9, 0, 1, 0, 1, 0);
`ifdef STICKY_OVF_EN
            chk($sformatf("sticky.hold%0d", i), 32'(ovf_sticky), 32'd1);
`endif
        end

`ifdef STICKY_OVF_EN
        // Clear wins over a simultaneous overflow capture
        @(negedge clk);
        sticky_clr = 1'b1; in_valid = 1'b1; A = 4'b0111; B = 4'b0001; Cin = 1'b0;
        @(posedge clk); #1;
        chk("sticky.clrwins", 32'(ovf_sticky), 32'd0);
        chk("sticky.clr.ovf_q", 32'(ovf_q), 32'd1);
        @(negedge clk);
        sticky_clr = 1'b0; A = 4'b0001; B = 4'b0001;
        @(posedge clk); #1;
        chk("sticky.stay0", 32'(ovf_sticky), 32'd0);
        chk("sticky.stay0.F_q", 32'(F_q), 32'h2);
`endif

        // More boundaries
        @(negedge clk);
        in_valid = 1'b0;
        A = 4'b1111; B = 4'b1111; Cin = 1'b1; #1;
        chk_comb("F+F+1", 4'b1111, 1, 0);
        A = 4'b1000; B = 4'b1000; Cin = 1'b0; #1;
        chk_comb("8+8", 4'b0000, 1, 1);
        A = 4'b0000; B = 4'b0000; Cin = 1'b0; #1;
        chk_comb("0+0", 4'b0000, 0, 0);

        // Reset asserted mid-stream between edges
        A = 4'b0101; B = 4'b0110; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk_reg("cap5+6", 4'hB, 0, 1, 0, 1, 1);
        #2;
        rst = 1'b1; #1;
        chk_reg("rstmid", 4'h0, 0, 0, 1, 0, 0);
        chk_comb("rstmid.comb", 4'b1011, 0, 1);
`ifdef STICKY_OVF_EN
        chk("rstmid.sticky", 32'(ovf_sticky), 32'd0);
`endif
        @(posedge clk); #1;
        chk_reg("rsthold", 4'h0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        A = 4'b0010; B = 4'b0011; Cin = 1'b0;
        @(posedge clk); #1;
        chk_reg("afterrst", 4'h5, 0, 0, 0, 0, 1);

        // Full operand sweep against an arithmetic model
        @(negedge clk);
        in_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int sa, sb, s;
                    A = 4'(a); B = 4'(b); Cin = 1'(c); #1;
                    sa = (a >= 8) ? a - 16 : a;
                    sb = (b >= 8) ? b - 16 : b;
                    s  = sa + sb + c;
                    chk($sformatf("sweep.sum %0d+%0d+%0d", a, b, c), 32'({Cout, F}), 32'(a + b + c));
                    chk($sformatf("sweep.ovf %0d+%0d+%0d", a, b, c), 32'(overflow),
                        32'((s > 7) || (s < -8)));
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
